spm_loader: RTL and testbench
=============================

# spm_loader

Bus initiator that drives one SPM port (the same address, strobe, read/write and data signals the IF and MEM stages use) to bulk-load a program image. It takes a byte stream over a valid/ready handshake and packs it into 32-bit little-endian words. Each word is written to consecutive SPM word addresses. A read-back pass then checks the image against a running checksum. It sits between the host/UART receive path and the SPM port muxed in front of the core, and holds the core off while busy.

## Interface
Parameters:
- ADDR_W, 12, SPM word-address width (4096 words).
- CNT_W, 13, word-count width (allows a count of 4096).

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; ignored while busy.
- base_addr  in  ADDR_W  first SPM word address; sampled on start.
- word_cnt  in  CNT_W  number of words to load; sampled on start.
- rx_data  in  8  stream byte.
- rx_valid  in  1  stream byte valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- ld_spm_addr  out  ADDR_W  SPM address.
- ld_spm_as_  out  1  address strobe, active-low (`ENABLE_`).
- ld_spm_rw  out  1  `WRITE` / `READ`.
- ld_spm_wr_data  out  32  write data.
- ld_spm_rd_data  in  32  SPM read data; valid the cycle after the strobed read address.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle completion pulse.
- error  out  1  checksum mismatch; held until the next accepted start or reset.

## Operation
States: IDLE, RECV, WR, VERIFY, CHECK, FIN.
- **IDLE**
  - start latches base_addr into the address pointer and word_cnt into the remaining counter.
  - start also clears the byte index, both sums and error.
  - Next state is RECV, or FIN if word_cnt==0.
- **RECV**
  - rx_ready=1.
  - Each handshake (rx_valid&rx_ready) shifts the byte into the word buffer at byte index 0..3 (index 0 = bits 7:0).
  - On the 4th byte, next state is WR.
- **WR**
  - One cycle: as_=`ENABLE_`, rw=`WRITE`, addr=pointer, wr_data=assembled word; rx_ready=0.
  - wr_sum += word, modulo 2^32.
  - Pointer increments; remaining count decrements.
  - Next state is RECV if words remain; otherwise VERIFY, with pointer reloaded to the latched base and remaining count to the latched word_cnt.
- **VERIFY**
  - Each cycle: as_=`ENABLE_`, rw=`READ`, addr=pointer; pointer increments.
  - From the second VERIFY cycle onward, rd_sum += ld_spm_rd_data.
  - After the word_cnt-th read, next state is CHECK.
- **CHECK**
  - as_ deasserted.
  - Accumulate the final read word.
  - error <= (rd_sum_final != wr_sum).
  - Next state is FIN.
- **FIN**: done=1 for one cycle, busy=0 in that cycle; next state is IDLE.

Address arithmetic is ADDR_W bits: base 0xFFE with 3 words writes 0xFFE, 0xFFF, 0x000.

When idle, outputs are as_=~`ENABLE_`, rw=`READ`, addr=0, wr_data=0.

## Timing
- Reset values: state IDLE, rx_ready=0, ld_spm_as_=1 (disabled), ld_spm_rw=`READ`, ld_spm_addr=0, ld_spm_wr_data=0, busy=0, done=0, error=0.
- Reset mid-operation: the strobe deasserts in the first cycle after the reset edge, the partial word is discarded, and no done pulse is produced.
- All outputs are registered.
- start is accepted only in IDLE. A start coincident with FIN's done cycle is ignored.
- rx_valid may drop at any time. The loader simply waits in RECV; there is no timeout.
- Latency:
  - With back-to-back bytes, N words take 5N cycles in RECV/WR.
  - VERIFY takes N cycles, then CHECK 1 cycle, then FIN 1 cycle.
  - Total from start to done is 6N+3 cycles.
  - word_cnt==0: done is asserted 2 cycles after start, with no SPM access.
- The SPM read latency of exactly one cycle is fixed; no handshake exists on the SPM side.

## Structure
- Shared package or defines additions: the state encodings (`LD_IDLE`..`LD_FIN`), the `SPM_ADDR_W` and `SPM_DEPTH` constants, and reuse of the existing `ENABLE_`, `READ` and `WRITE` macros.
- Sub-module: `byte_packer` (byte index counter, little-endian shift register, word-complete flag). Everything else stays in one module.

## Test plan
- Basic load: start, base=0x010, cnt=2, bytes 78 56 34 12 EF BE AD DE back-to-back, with an SPM model attached.
  - Required: writes of 0x12345678 at 0x010 and 0xDEADBEEF at 0x011.
  - Required: reads at 0x010 and 0x011; done after 15 cycles; error=0.
- Throttled stream: the same image with rx_valid toggling 1,0,0,1.
  - Required: identical SPM contents; rx_ready low in WR cycles only; done and error=0.
- Wrap: base=0xFFE, cnt=3.
  - Required: write addresses 0xFFE, 0xFFF, 0x000, then reads in the same order.
- Corruption: the SPM model flips bit 0 of address 0x011 on readback.
  - Required: error=1 with done, held until the next start; the next clean load clears it.
- Edge starts:
  - word_cnt=0: done 2 cycles later, as_ never asserted.
  - start pulsed while busy: ignored, addresses unchanged.
- Reset mid-load: reset asserted after 6 bytes of a 4-word load.
  - Required: as_=1 and busy=0 in the next cycle, no done pulse.
  - Required: a subsequent load of 1 word completes correctly.

Source files
------------

// File: rtl/spm_loader_pkg.sv
// Shared definitions for the SPM program loader.
package spm_loader_pkg;

  localparam int unsigned SpmAddrW = 12;
  localparam int unsigned SpmDepth = 1 << SpmAddrW;

  // SPM bus encodings: the address strobe is active-low.
  localparam logic SpmEnableN  = 1'b0;
  localparam logic SpmDisableN = 1'b1;
  localparam logic SpmRead     = 1'b1;
  localparam logic SpmWrite    = 1'b0;

  typedef enum logic [2:0] {
    LdIdle   = 3'd0,
    LdRecv   = 3'd1,
    LdWr     = 3'd2,
    LdVerify = 3'd3,
    LdCheck  = 3'd4,
    LdFin    = 3'd5
  } ld_state_e;

  // States in which the loader drives a strobed SPM access.
  function automatic logic is_bus_state(ld_state_e s);
    return (s == LdWr) || (s == LdVerify);
  endfunction

endpackage

// File: rtl/spm_loader_packer.sv
// Little-endian byte-to-word packer: byte index, shift buffer, word-complete flag.
module byte_packer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic [31:0] word_o,
  output logic        complete_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;

  // Merge an accepted byte into its lane; word_o includes the byte being accepted now.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (valid_i) begin
      idx_d                        = idx_q + 2'd1;
      word_d[{idx_q, 3'b000} +: 8] = data_i;
    end
  end

  assign word_o     = word_d;
  assign complete_o = valid_i && !clear_i && (idx_q == 2'd3);

  // Byte index and buffer registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/spm_loader.sv
// Bulk loader: packs a byte stream into SPM words, then reads them back and checks a sum.
import spm_loader_pkg::*;

module spm_loader #(
  parameter int unsigned ADDR_W = SpmAddrW,
  parameter int unsigned CNT_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] ld_spm_addr,
  output logic              ld_spm_as_,
  output logic              ld_spm_rw,
  output logic [31:0]       ld_spm_wr_data,
  input  logic [31:0]       ld_spm_rd_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, base_q, base_d;
  logic [CNT_W-1:0]  total_q, total_d, remain_q, remain_d;
  logic [31:0]       wr_sum_q, wr_sum_d, rd_sum_q, rd_sum_d;
  logic              rd_pend_q, rd_pend_d;
  logic              error_q, error_d;

  // Output registers, loaded from next-state values so they line up with the state.
  logic              ready_q, ready_d, as_q, as_d, rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic              accept;
  logic              hs;
  logic [31:0]       pk_word;
  logic              pk_complete;

  assign accept = (state_q == LdIdle) && start;
  assign hs     = rx_valid && ready_q;

  byte_packer u_packer (
    .clk_i      (clk),
    .reset_i    (reset),
    .clear_i    (accept),
    .data_i     (rx_data),
    .valid_i    (hs),
    .word_o     (pk_word),
    .complete_o (pk_complete)
  );

  // Next-state, pointer, counters and checksums.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    base_d    = base_q;
    total_d   = total_q;
    remain_d  = remain_q;
    wr_sum_d  = wr_sum_q;
    rd_sum_d  = rd_sum_q;
    rd_pend_d = 1'b0;
    error_d   = error_q;
    unique case (state_q)
      LdIdle: begin
        if (start) begin
          base_d   = base_addr;
          ptr_d    = base_addr;
          total_d  = word_cnt;
          remain_d = word_cnt;
          wr_sum_d = '0;
          rd_sum_d = '0;
          error_d  = 1'b0;
          state_d  = (word_cnt == '0) ? LdFin : LdRecv;
        end
      end
      LdRecv: begin
        if (pk_complete) state_d = LdWr;
      end
      LdWr: begin
        wr_sum_d = wr_sum_q + wdata_q;
        if (remain_q == CNT_W'(1)) begin
          ptr_d    = base_q;
          remain_d = total_q;
          state_d  = LdVerify;
        end else begin
          ptr_d    = ptr_q + ADDR_W'(1);
          remain_d = remain_q - CNT_W'(1);
          state_d  = LdRecv;
        end
      end
      LdVerify: begin
        // Read data trails its address by one cycle, so the first cycle has nothing to add.
        ptr_d     = ptr_q + ADDR_W'(1);
        remain_d  = remain_q - CNT_W'(1);
        rd_pend_d = 1'b1;
        if (rd_pend_q) rd_sum_d = rd_sum_q + ld_spm_rd_data;
        if (remain_q == CNT_W'(1)) state_d = LdCheck;
      end
      LdCheck: begin
        rd_sum_d = rd_sum_q + ld_spm_rd_data;
        error_d  = (rd_sum_d != wr_sum_q);
        state_d  = LdFin;
      end
      LdFin: begin
        state_d = LdIdle;
      end
      default: state_d = LdIdle;
    endcase
  end

  // Bus and status outputs for the cycle the next state will occupy.
  always_comb begin
    ready_d = (state_d == LdRecv);
    as_d    = is_bus_state(state_d) ? SpmEnableN : SpmDisableN;
    rw_d    = (state_d == LdWr) ? SpmWrite : SpmRead;
    addr_d  = is_bus_state(state_d) ? ptr_d : '0;
    wdata_d = (state_d == LdWr) ? pk_word : '0;
    busy_d  = (state_d != LdIdle) && (state_d != LdFin);
    done_d  = (state_d == LdFin);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LdIdle;
      ptr_q     <= '0;
      base_q    <= '0;
      total_q   <= '0;
      remain_q  <= '0;
      wr_sum_q  <= '0;
      rd_sum_q  <= '0;
      rd_pend_q <= 1'b0;
      error_q   <= 1'b0;
      ready_q   <= 1'b0;
      as_q      <= SpmDisableN;
      rw_q      <= SpmRead;
      addr_q    <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      base_q    <= base_d;
      total_q   <= total_d;
      remain_q  <= remain_d;
      wr_sum_q  <= wr_sum_d;
      rd_sum_q  <= rd_sum_d;
      rd_pend_q <= rd_pend_d;
      error_q   <= error_d;
      ready_q   <= ready_d;
      as_q      <= as_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rx_ready       = ready_q;
  assign ld_spm_as_     = as_q;
  assign ld_spm_rw      = rw_q;
  assign ld_spm_addr    = addr_q;
  assign ld_spm_wr_data = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_spm_loader.sv
// Bench for spm_loader: directed table, hand-written corner sequences, random loads.
module tb_spm_loader;
  import spm_loader_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned CW = 13;

  logic          clk = 1'b0;
  logic          reset, start, rx_valid, rx_ready;
  logic [AW-1:0] base_addr, ld_spm_addr;
  logic [CW-1:0] word_cnt;
  logic [7:0]    rx_data;
  logic          ld_spm_as_, ld_spm_rw, busy, done, error;
  logic [31:0]   ld_spm_wr_data, ld_spm_rd_data;

  always #5 clk = ~clk;

  spm_loader #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .word_cnt       (word_cnt),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .ld_spm_addr    (ld_spm_addr),
    .ld_spm_as_     (ld_spm_as_),
    .ld_spm_rw      (ld_spm_rw),
    .ld_spm_wr_data (ld_spm_wr_data),
    .ld_spm_rd_data (ld_spm_rd_data),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  // SPM model: one-cycle read latency, optional bit-0 flip on readback of 0x011.
  typedef struct { logic [AW-1:0] addr; logic [31:0] data; } xfer_t;
  xfer_t         wr_log[$];
  logic [AW-1:0] rd_log[$];
  logic [31:0]   mem [SpmDepth];
  bit            corrupt = 1'b0;

  always @(posedge clk) begin
    if (ld_spm_as_ == SpmEnableN) begin
      if (ld_spm_rw == SpmWrite) begin
        mem[ld_spm_addr] <= ld_spm_wr_data;
        wr_log.push_back('{ld_spm_addr, ld_spm_wr_data});
      end else begin
        ld_spm_rd_data <= mem[ld_spm_addr] ^
                          ((corrupt && ld_spm_addr == 12'h011) ? 32'h1 : 32'h0);
        rd_log.push_back(ld_spm_addr);
      end
    end
  end

  // Mid-cycle monitor: start/done timing, strobe count, rx_ready vs write-cycle rule.
  int cyc = 0, start_cyc = 0, done_cyc = 0, done_total = 0, strobe_total = 0, rdy_viol = 0;
  bit done_err = 1'b0, seen_read = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (start && !busy && !done && !reset) begin
      start_cyc = cyc;
      seen_read = 1'b0;
    end
    if (done) begin
      done_total++;
      done_cyc = cyc;
      done_err = error;
    end
    if (ld_spm_as_ == SpmEnableN) strobe_total++;
    if (ld_spm_as_ == SpmEnableN && ld_spm_rw == SpmRead) seen_read = 1'b1;
    if (busy && !seen_read &&
        (rx_ready == (ld_spm_as_ == SpmEnableN && ld_spm_rw == SpmWrite))) rdy_viol++;
  end

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] img[$];

  function automatic logic [31:0] model_word(input int i);
    return 32'(img[4*i]) + 32'(img[4*i+1]) * 256 + 32'(img[4*i+2]) * 65536 +
           32'(img[4*i+3]) * 16777216;
  endfunction

  function automatic int model_addr(input logic [AW-1:0] b, input int i);
    return (int'(b) + i) % SpmDepth;
  endfunction

  // One complete load; mode 0 back-to-back, 1 valid pattern 1,0,0,1, 2 random valid.
  task automatic run_load(input logic [AW-1:0] b, input int n, input int mode, input bit corr,
                          input bit poke, output logic [31:0] first_data,
                          output logic [AW-1:0] last_addr, output bit err_seen);
    int w0 = wr_log.size();
    int r0 = rd_log.size();
    int d0 = done_total;
    int s0 = strobe_total;
    int v0 = rdy_viol;
    int k = 0, g = 0, nbad = 0;
    bit hs, exp_err = 1'b0;
    corrupt   = corr;
    base_addr = b;
    word_cnt  = CW'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    base_addr = AW'($urandom);
    word_cnt  = CW'($urandom);
    while (k < 4 * n && g < 2000) begin
      case (mode)
        0:       rx_valid = 1'b1;
        1:       rx_valid = (g % 4 == 0) || (g % 4 == 3);
        default: rx_valid = ($urandom_range(0, 2) != 0);
      endcase
      rx_data = rx_valid ? img[k] : 8'($urandom);
      if (poke && g == 2) begin
        start     = 1'b1;
        base_addr = b ^ 12'h080;
        word_cnt  = CW'(1);
      end
      @(negedge clk);
      hs = rx_valid && rx_ready;
      tick();
      start = 1'b0;
      if (hs) k++;
      g++;
    end
    rx_valid = 1'b0;
    check("feed_bound", k, 4 * n);
    g = 0;
    while (done_total == d0 && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    tick();
    check("done_pulses", done_total - d0, 1);
    if (mode == 0) check("latency", done_cyc - start_cyc + 1, (n == 0) ? 2 : 6 * n + 3);
    for (int i = 0; i < n; i++) if (corr && model_addr(b, i) == 'h011) exp_err = 1'b1;
    check("error_model", done_err, exp_err);
    check("wr_count", wr_log.size() - w0, n);
    check("rd_count", rd_log.size() - r0, n);
    for (int i = 0; i < n; i++) begin
      if (w0 + i >= wr_log.size() || r0 + i >= rd_log.size()) nbad++;
      else if (wr_log[w0+i].addr != AW'(model_addr(b, i)) ||
               wr_log[w0+i].data != model_word(i) ||
               rd_log[r0+i] != AW'(model_addr(b, i)) ||
               mem[model_addr(b, i)] != model_word(i)) nbad++;
    end
    check("xfer_mismatches", nbad, 0);
    check("rx_ready_rule", rdy_viol - v0, 0);
    if (n == 0) check("no_strobe", strobe_total - s0, 0);
    first_data = (wr_log.size() > w0) ? wr_log[w0].data : 32'hx;
    last_addr  = (wr_log.size() > w0) ? wr_log[wr_log.size()-1].addr : 'x;
    err_seen   = done_err;
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            n;
    int            mode;
    bit            corr;
    bit            poke;
    logic [31:0]   exp_first;
    logic [AW-1:0] exp_last;
    bit            exp_err;
  } vec_t;

  vec_t          vecs[7];
  logic [31:0]   fd;
  logic [AW-1:0] la;
  bit            es;
  int            d_before;

  initial begin
    vecs[0] = '{12'h010, 2, 0, 1'b0, 1'b0, 32'h12345678, 12'h011, 1'b0};  // basic
    vecs[1] = '{12'h010, 2, 1, 1'b0, 1'b0, 32'h12345678, 12'h011, 1'b0};  // throttled
    vecs[2] = '{12'hFFE, 3, 0, 1'b0, 1'b0, 32'h12345678, 12'h000, 1'b0};  // wrap
    vecs[3] = '{12'h010, 2, 0, 1'b1, 1'b0, 32'h12345678, 12'h011, 1'b1};  // corrupt
    vecs[4] = '{12'h010, 2, 2, 1'b0, 1'b0, 32'h12345678, 12'h011, 1'b0};  // clean clears
    vecs[5] = '{12'h100, 2, 0, 1'b0, 1'b1, 32'h12345678, 12'h101, 1'b0};  // start while busy
    vecs[6] = '{12'h123, 0, 0, 1'b0, 1'b0, 32'h0, 12'h000, 1'b0};         // zero words

    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    base_addr = '0; word_cnt = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_as", ld_spm_as_, SpmDisableN);
    check("rst_rw", ld_spm_rw, SpmRead);
    check("rst_addr", ld_spm_addr, 0);
    check("rst_wdata", ld_spm_wr_data, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    img = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
            8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 7; i++) begin
      run_load(vecs[i].base, vecs[i].n, vecs[i].mode, vecs[i].corr, vecs[i].poke, fd, la, es);
      check($sformatf("vec%0d_error", i), es, vecs[i].exp_err);
      if (vecs[i].n != 0) begin
        check($sformatf("vec%0d_first_data", i), fd, vecs[i].exp_first);
        check($sformatf("vec%0d_last_addr", i), la, vecs[i].exp_last);
      end
      if (vecs[i].corr) begin
        repeat (3) tick();
        @(negedge clk);
        check("error_held", error, 1'b1);
        tick();
      end
    end

    // Reset after six bytes of a four-word load.
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(8'($urandom));
    d_before  = done_total;
    corrupt   = 1'b0;
    base_addr = 12'h200;
    word_cnt  = CW'(4);
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0, g = 0; k < 6 && g < 100; g++) begin
      rx_valid = 1'b1;
      rx_data  = img[k];
      @(negedge clk);
      if (rx_ready) k++;
      tick();
    end
    rx_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_as", ld_spm_as_, SpmDisableN);
    check("midrst_busy", busy, 1'b0);
    repeat (20) tick();
    check("midrst_no_done", done_total - d_before, 0);
    run_load(12'h300, 1, 0, 1'b0, 1'b0, fd, la, es);
    check("after_rst_word", fd, model_word(0));

    // Random loads against the model.
    for (int t = 0; t < 8; t++) begin
      int n = $urandom_range(1, 6);
      logic [AW-1:0] b = (t % 2 == 0) ? AW'($urandom) : AW'($urandom_range(12'h00C, 12'h011));
      img.delete();
      for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
      run_load(b, n, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0, fd, la, es);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
